// File: rtl/idct8_pkg.sv
// Shared definitions for the 8-point IDCT: parameter defaults, FSM states and
// the fixed-point cosine table C[k][n] scaled by 2^11.
package idct8_pkg;

    localparam int COEF_W_DEFAULT = 12;
    localparam int PIX_W_DEFAULT  = 8;
    localparam int FRAC_DEFAULT   = 11;
    localparam int CONST_W        = 13;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Row k, column n: round(2^11 * c(k)/2 * cos((2n+1)k*pi/16)).
    localparam logic signed [CONST_W-1:0] C_TABLE [8][8] = '{
        '{ 13'sd724,   13'sd724,   13'sd724,   13'sd724,   13'sd724,   13'sd724,   13'sd724,   13'sd724 },
        '{ 13'sd1004,  13'sd851,   13'sd569,   13'sd200,  -13'sd200,  -13'sd569,  -13'sd851,  -13'sd1004 },
        '{ 13'sd946,   13'sd392,  -13'sd392,  -13'sd946,  -13'sd946,  -13'sd392,   13'sd392,   13'sd946 },
        '{ 13'sd851,  -13'sd200,  -13'sd1004, -13'sd569,   13'sd569,   13'sd1004,  13'sd200,  -13'sd851 },
        '{ 13'sd724,  -13'sd724,  -13'sd724,   13'sd724,   13'sd724,  -13'sd724,  -13'sd724,   13'sd724 },
        '{ 13'sd569,  -13'sd1004,  13'sd200,   13'sd851,  -13'sd851,  -13'sd200,   13'sd1004, -13'sd569 },
        '{ 13'sd392,  -13'sd946,   13'sd946,  -13'sd392,  -13'sd392,   13'sd946,  -13'sd946,   13'sd392 },
        '{ 13'sd200,  -13'sd569,   13'sd851,  -13'sd1004,  13'sd1004, -13'sd851,   13'sd569,  -13'sd200 }
    };

endpackage

// File: rtl/idct8_mac.sv
// Combinational single-pixel IDCT: dot product of the 8 coefficients with
// table column n, then round, level-shift by 128 and clamp to the pixel range.
module idct8_mac
    import idct8_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT,
    parameter int PIX_W  = PIX_W_DEFAULT,
    parameter int FRAC   = FRAC_DEFAULT
) (
    input  logic signed [COEF_W-1:0] coef [8],
    input  logic        [2:0]        n,
    output logic        [PIX_W-1:0]  pixel
);

    localparam int ACC_W = COEF_W + FRAC + 4;
    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SHIFT   = ACC_W'(128);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(2 ** PIX_W - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] level;

    always_comb begin
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc = acc + ACC_W'(coef[k]) * ACC_W'(C_TABLE[k][n]);
        end
    end

    // Arithmetic shift keeps negative sums rounding toward the nearest value.
    always_comb begin
        level = ((acc + HALF) >>> FRAC) + SHIFT;
        if (level < 0) begin
            pixel = '0;
        end else if (level > PIX_MAX) begin
            pixel = '1;
        end else begin
            pixel = level[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/idct8.sv
// 8-point 1-D IDCT: loads 8 coefficients, computes one pixel per cycle with a
// shared MAC, then streams the 8 pixels out under valid/ready handshaking.
module idct8
    import idct8_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT,
    parameter int PIX_W  = PIX_W_DEFAULT,
    parameter int FRAC   = FRAC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [COEF_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic        [PIX_W-1:0]  out_data,
    output logic                     out_last,
    input  logic                     out_ready
);

    state_t                   state;
    logic        [2:0]        idx;
    logic signed [COEF_W-1:0] coef    [8];
    logic        [PIX_W-1:0]  pix_buf [8];
    logic        [PIX_W-1:0]  pixel;
    logic                     in_fire;
    logic                     out_fire;

    // A single index serves as coefficient, compute and emit pointer.
    assign in_ready  = rst_n && (state == LOAD);
    assign out_valid = (state == EMIT);
    assign out_data  = out_valid ? pix_buf[idx] : '0;
    assign out_last  = out_valid && (idx == 3'd7);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    idct8_mac #(
        .COEF_W (COEF_W),
        .PIX_W  (PIX_W),
        .FRAC   (FRAC)
    ) u_mac (
        .coef  (coef),
        .n     (idx),
        .pixel (pixel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            idx   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= LOAD;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                    idx   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            coef[idx] <= in_data;
        end
        if (state == COMPUTE) begin
            pix_buf[idx] <= pixel;
        end
    end

endmodule

// File: tb/tb_idct8.sv
// Randomised bench for idct8 against a floating-point-derived reference IDCT,
// plus directed DC, clamp, backpressure and reset scenarios.
`timescale 1ns/1ps
module tb_idct8;

    localparam int COEF_W = 12;
    localparam int PIX_W  = 8;
    localparam int FRAC   = 11;
    localparam int BUDGET = 400;

    typedef int block_t [8];

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              in_valid  = 1'b0;
    logic [COEF_W-1:0] in_data   = '0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic              out_last;
    logic [PIX_W-1:0]  out_data;

    int vectors     = 0;
    int miscompares = 0;
    int ctab [8][8];

    idct8 #(
        .COEF_W (COEF_W),
        .PIX_W  (PIX_W),
        .FRAC   (FRAC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int roundReal(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    task automatic buildTable();
        real pi;
        real ck;
        pi = 3.14159265358979;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                ctab[k][n] = roundReal(real'(1 << FRAC) * ck / 2.0 * $cos(real'((2 * n + 1) * k) * pi / 16.0));
            end
        end
    endtask

    function automatic int refPixel(input block_t x, input int n);
        int acc;
        int v;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            acc += x[k] * ctab[k][n];
        end
        v = ((acc + (1 << (FRAC - 1))) >>> FRAC) + 128;
        if (v < 0) v = 0;
        if (v > (1 << PIX_W) - 1) v = (1 << PIX_W) - 1;
        return v;
    endfunction

    // stall_pct < 0 selects a fixed 5-cycle stall on pixel 3; fixed_exp >= 0
    // overrides the model with a known constant pixel value.
    task automatic applyStimulus(input block_t x, input int gap_pct, input int stall_pct, input int fixed_exp);
        int exp_pix [8];
        int loaded   = 0;
        int emitted  = 0;
        int cyc      = 0;
        int x7_cyc   = -1;
        int hold_cnt = 0;
        bit stalled  = 1'b0;
        logic [PIX_W-1:0] held_data = '0;
        logic             held_last = 1'b0;
        for (int n = 0; n < 8; n++) begin
            exp_pix[n] = (fixed_exp >= 0) ? fixed_exp : refPixel(x, n);
        end
        while (emitted < 8 && cyc < BUDGET) begin
            @(negedge clk);
            if (loaded < 8) begin
                in_valid = (int'($urandom_range(99)) >= gap_pct);
                in_data  = in_valid ? COEF_W'(x[loaded]) : COEF_W'($urandom);
            end else begin
                in_valid = 1'($urandom_range(1));
                in_data  = COEF_W'($urandom);
            end
            if (stall_pct < 0) begin
                out_ready = !(emitted == 3 && hold_cnt < 5);
            end else begin
                out_ready = (int'($urandom_range(99)) >= stall_pct);
            end
            #1;
            if (stalled) begin
                checkOutput("hold_data", out_data, held_data);
                checkOutput("hold_last", out_last, held_last);
            end
            checkOutput("in_ready", in_ready, loaded < 8);
            checkOutput("out_valid", out_valid, x7_cyc >= 0 && cyc - x7_cyc >= 9);
            if (in_valid && in_ready && loaded < 8) begin
                if (loaded == 7) x7_cyc = cyc;
                loaded++;
            end
            stalled = out_valid && !out_ready;
            if (stalled) begin
                held_data = out_data;
                held_last = out_last;
                if (emitted == 3) hold_cnt++;
            end
            if (out_valid && out_ready) begin
                checkOutput("pixel", out_data, exp_pix[emitted]);
                checkOutput("out_last", out_last, emitted == 7);
                emitted++;
            end
            cyc++;
        end
        checkOutput("block_done", emitted, 8);
    endtask

    block_t blk;

    initial begin
        buildTable();

        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready", in_ready, 1);

        blk = '{0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(blk, 0, 0, 128);
        blk = '{8, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(blk, 0, 0, 131);
        blk = '{1000, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(blk, 0, 0, 255);
        blk = '{-1000, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(blk, 0, 0, 0);
        blk = '{40, -75, 120, 33, -18, 90, -5, 61};
        applyStimulus(blk, 0, -1, -1);

        // Partial block interrupted by reset must never surface.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = COEF_W'($urandom);
            out_ready = 1'b1;
            #1;
            checkOutput("partial_no_valid", out_valid, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_release_in_ready", in_ready, 1);
        blk = '{8, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(blk, 0, 0, 131);

        for (int b = 0; b < 1000; b++) begin
            for (int k = 0; k < 8; k++) begin
                blk[k] = (b % 2 == 1) ? int'($urandom_range(4095)) - 2048
                                      : int'($urandom_range(400)) - 200;
            end
            applyStimulus(blk, 25, 25, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
